// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl
// Game Boy CPU interrupt controller: IE/IF registers, IME with the EI delay,
// vector latch for dispatch and the RUN/HALT low-power state machine.
// Optional feature macro: GB_CPU_HALT_BUG_EN (implements the halt_bug pulse;
// when undefined halt_bug is tied low).
module gb_cpu_interrupt_ctrl #(
  parameter int NUM_IRQ = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               ie_wr,
  input  logic               if_wr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         ie_o,
  output logic [7:0]         if_o,
  input  logic               enable_interrupts,
  input  logic               reti_enable,
  input  logic               disable_interrupts,
  input  logic               write_interrupt_vector,
  input  logic               clear_interrupt_flag,
  input  logic               instr_boundary,
  input  logic               halt_req,
  output logic               interrupt_queued,
  output logic [7:0]         isr_vector,
  output logic               ime_o,
  output logic               halted,
  output logic               halt_bug
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  logic [7:0]         ie_reg;
  logic [NUM_IRQ-1:0] if_reg;
  logic               ime;
  logic               ime_pending;
  logic               vec_valid;
  logic [2:0]         vec_idx;
  state_t             state;

  logic [NUM_IRQ-1:0] pending;
  logic               any_pending;
  logic [2:0]         lat_idx;
  logic               lat_valid;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] if_base;

  // Lowest set bit wins: VBlank (bit 0) has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [2:0] idx);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (idx == 3'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign pending     = ie_reg[NUM_IRQ-1:0] & if_reg;
  assign any_pending = |pending;

  // A vector latched in the same cycle as the acknowledge is cleared at once.
  always_comb begin
    lat_idx   = write_interrupt_vector ? lowest_set(pending) : vec_idx;
    lat_valid = write_interrupt_vector ? any_pending : vec_valid;
    clr_mask  = (clear_interrupt_flag && lat_valid) ? onehot(lat_idx) : '0;
    if_base   = if_wr ? reg_wdata[NUM_IRQ-1:0] : if_reg;
  end

  // IE/IF registers: new requests override same-cycle writes and clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_reg <= 8'h00;
      if_reg <= '0;
    end else begin
      if (ie_wr) ie_reg <= reg_wdata;
      if_reg <= (if_base & ~clr_mask) | irq_req;
    end
  end

  // IME and the one-instruction EI delay; DI has the final say.
  always_ff @(posedge clk) begin
    if (reset) begin
      ime         <= 1'b0;
      ime_pending <= 1'b0;
    end else begin
      logic ime_n, pend_n;
      ime_n  = ime;
      pend_n = ime_pending;
      if (ime_pending && instr_boundary) begin
        ime_n  = 1'b1;
        pend_n = 1'b0;
      end
      if (enable_interrupts && !ime) pend_n = 1'b1;
      if (reti_enable) begin
        ime_n  = 1'b1;
        pend_n = 1'b0;
      end
      if (clear_interrupt_flag || disable_interrupts) begin
        ime_n  = 1'b0;
        pend_n = 1'b0;
      end
      ime         <= ime_n;
      ime_pending <= pend_n;
    end
  end

  // Dispatch vector latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_valid <= 1'b0;
      vec_idx   <= 3'd0;
    end else begin
      if (write_interrupt_vector) vec_idx <= lowest_set(pending);
      if (clear_interrupt_flag) vec_valid <= 1'b0;
      else if (write_interrupt_vector) vec_valid <= any_pending;
    end
  end

  // RUN/HALT state machine; HALT is left on any pending source regardless of IME.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (halt_req && !any_pending) state <= ST_HALT;
        ST_HALT: if (any_pending) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef GB_CPU_HALT_BUG_EN
  logic halt_bug_r;

  // HALT with IME clear and a pending source: one-cycle halt bug pulse.
  always_ff @(posedge clk) begin
    if (reset) halt_bug_r <= 1'b0;
    else halt_bug_r <= halt_req && (state == ST_RUN) && any_pending && !ime;
  end

  assign halt_bug = halt_bug_r;
`else
  assign halt_bug = 1'b0;
`endif

  assign ie_o             = ie_reg;
  assign if_o             = {{(8-NUM_IRQ){1'b1}}, if_reg};
  assign interrupt_queued = ime & any_pending;
  assign isr_vector       = vec_valid ? (8'h40 + {2'b00, vec_idx, 3'b000}) : 8'h00;
  assign ime_o            = ime;
  assign halted           = (state == ST_HALT);

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed bench for gb_cpu_interrupt_ctrl (default NUM_IRQ = 5).
module tb_gb_cpu_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] irq_req;
  logic       ie_wr, if_wr;
  logic [7:0] reg_wdata;
  logic [7:0] ie_o, if_o;
  logic       enable_interrupts, reti_enable, disable_interrupts;
  logic       write_interrupt_vector, clear_interrupt_flag;
  logic       instr_boundary, halt_req;
  logic       interrupt_queued;
  logic [7:0] isr_vector;
  logic       ime_o, halted, halt_bug;

  int checks   = 0;
  int failures = 0;

  gb_cpu_interrupt_ctrl #(.NUM_IRQ(5)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req),
    .ie_wr(ie_wr), .if_wr(if_wr), .reg_wdata(reg_wdata),
    .ie_o(ie_o), .if_o(if_o),
    .enable_interrupts(enable_interrupts), .reti_enable(reti_enable),
    .disable_interrupts(disable_interrupts),
    .write_interrupt_vector(write_interrupt_vector),
    .clear_interrupt_flag(clear_interrupt_flag),
    .instr_boundary(instr_boundary), .halt_req(halt_req),
    .interrupt_queued(interrupt_queued), .isr_vector(isr_vector),
    .ime_o(ime_o), .halted(halted), .halt_bug(halt_bug)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 1'b0; irq_req = 5'h00; ie_wr = 1'b0; if_wr = 1'b0; reg_wdata = 8'h00;
    enable_interrupts = 1'b0; reti_enable = 1'b0; disable_interrupts = 1'b0;
    write_interrupt_vector = 1'b0; clear_interrupt_flag = 1'b0;
    instr_boundary = 1'b0; halt_req = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then return all inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic write_ie(input logic [7:0] v);
    ie_wr = 1'b1; reg_wdata = v; step();
  endtask

  task automatic write_if(input logic [7:0] v);
    if_wr = 1'b1; reg_wdata = v; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_req = 5'h1F; ie_wr = 1'b1; reg_wdata = 8'hFF; reti_enable = 1'b1;
    step();
    checks++; if (ie_o !== 8'h00) begin failures++; $display("FAIL reset_ie got=%h exp=00", ie_o); end
    checks++; if (if_o !== 8'hE0) begin failures++; $display("FAIL reset_if got=%h exp=e0", if_o); end
    checks++; if (ime_o !== 1'b0 || interrupt_queued !== 1'b0) begin failures++; $display("FAIL reset_ime got=%b/%b exp=0/0", ime_o, interrupt_queued); end
    checks++; if (isr_vector !== 8'h00 || halted !== 1'b0 || halt_bug !== 1'b0) begin failures++; $display("FAIL reset_misc got=%h/%b/%b exp=00/0/0", isr_vector, halted, halt_bug); end
  endtask

  task automatic test_irq_basic();
    write_ie(8'h01);
    checks++; if (ie_o !== 8'h01) begin failures++; $display("FAIL ie_write got=%h exp=01", ie_o); end
    irq_req = 5'h01; step();
    checks++; if (if_o !== 8'hE1) begin failures++; $display("FAIL irq_set got=%h exp=e1", if_o); end
    checks++; if (interrupt_queued !== 1'b0) begin failures++; $display("FAIL queued_ime0 got=%b exp=0", interrupt_queued); end
    reti_enable = 1'b1; step();
    checks++; if (ime_o !== 1'b1 || interrupt_queued !== 1'b1) begin failures++; $display("FAIL reti_queue got=%b/%b exp=1/1", ime_o, interrupt_queued); end
    disable_interrupts = 1'b1; step();
    write_if(8'h00);
    write_ie(8'hA3);
    checks++; if (ie_o !== 8'hA3) begin failures++; $display("FAIL ie_high_bits got=%h exp=a3", ie_o); end
  endtask

  task automatic test_dispatch();
    write_ie(8'h1F);
    reti_enable = 1'b1; step();
    irq_req = 5'h14; step();
    checks++; if (if_o !== 8'hF4 || interrupt_queued !== 1'b1) begin failures++; $display("FAIL disp_pending got=%h/%b exp=f4/1", if_o, interrupt_queued); end
    write_interrupt_vector = 1'b1; step();
    checks++; if (isr_vector !== 8'h50) begin failures++; $display("FAIL vec_timer got=%h exp=50", isr_vector); end
    clear_interrupt_flag = 1'b1; step();
    checks++; if (if_o !== 8'hF0 || ime_o !== 1'b0) begin failures++; $display("FAIL ack_timer got=%h/%b exp=f0/0", if_o, ime_o); end
    checks++; if (isr_vector !== 8'h00) begin failures++; $display("FAIL vec_after_ack got=%h exp=00", isr_vector); end
    write_interrupt_vector = 1'b1; step();
    checks++; if (isr_vector !== 8'h60) begin failures++; $display("FAIL vec_joypad got=%h exp=60", isr_vector); end
    clear_interrupt_flag = 1'b1; step();
    checks++; if (if_o !== 8'hE0) begin failures++; $display("FAIL ack_joypad got=%h exp=e0", if_o); end
    write_interrupt_vector = 1'b1; step();
    checks++; if (isr_vector !== 8'h00) begin failures++; $display("FAIL vec_cancelled got=%h exp=00", isr_vector); end
    clear_interrupt_flag = 1'b1; step();
  endtask

  task automatic test_ei_delay();
    enable_interrupts = 1'b1; instr_boundary = 1'b1; step();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL ei_immediate got=%b exp=0", ime_o); end
    step();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL ei_no_boundary got=%b exp=0", ime_o); end
    instr_boundary = 1'b1; step();
    checks++; if (ime_o !== 1'b1) begin failures++; $display("FAIL ei_second_boundary got=%b exp=1", ime_o); end
    disable_interrupts = 1'b1; step();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL di got=%b exp=0", ime_o); end
    enable_interrupts = 1'b1; step();
    disable_interrupts = 1'b1; step();
    instr_boundary = 1'b1; step();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL ei_then_di got=%b exp=0", ime_o); end
    reti_enable = 1'b1; disable_interrupts = 1'b1; step();
    checks++; if (ime_o !== 1'b0) begin failures++; $display("FAIL di_over_reti got=%b exp=0", ime_o); end
  endtask

  task automatic test_halt();
    write_ie(8'h04);
    halt_req = 1'b1; step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_enter got=%b exp=1", halted); end
    step();
    irq_req = 5'h04; step();
    checks++; if (halted !== 1'b1 || if_o !== 8'hE4) begin failures++; $display("FAIL halt_wake_edge got=%b/%h exp=1/e4", halted, if_o); end
    step();
    checks++; if (halted !== 1'b0 || interrupt_queued !== 1'b0) begin failures++; $display("FAIL halt_exit got=%b/%b exp=0/0", halted, interrupt_queued); end
    reti_enable = 1'b1; step();
    halt_req = 1'b1; step();
    checks++; if (halted !== 1'b0 || interrupt_queued !== 1'b1 || halt_bug !== 1'b0) begin failures++; $display("FAIL halt_ime1 got=%b/%b/%b exp=0/1/0", halted, interrupt_queued, halt_bug); end
    disable_interrupts = 1'b1; step();
    write_if(8'h00);
    halt_req = 1'b1; step();
    reset = 1'b1; irq_req = 5'h04; step();
    checks++; if (halted !== 1'b0 || if_o !== 8'hE0 || ie_o !== 8'h00) begin failures++; $display("FAIL reset_in_halt got=%b/%h/%h exp=0/e0/00", halted, if_o, ie_o); end
  endtask

  task automatic test_same_cycle();
    write_ie(8'h01);
    write_if(8'h01);
    write_interrupt_vector = 1'b1; step();
    checks++; if (isr_vector !== 8'h40) begin failures++; $display("FAIL vec_vblank got=%h exp=40", isr_vector); end
    irq_req = 5'h01; clear_interrupt_flag = 1'b1; step();
    checks++; if (if_o !== 8'hE1) begin failures++; $display("FAIL req_beats_clear got=%h exp=e1", if_o); end
    write_ie(8'h03);
    write_if(8'h03);
    write_interrupt_vector = 1'b1; clear_interrupt_flag = 1'b1; step();
    checks++; if (if_o !== 8'hE2 || isr_vector !== 8'h00) begin failures++; $display("FAIL latch_and_clear got=%h/%h exp=e2/00", if_o, isr_vector); end
    if_wr = 1'b1; reg_wdata = 8'h00; irq_req = 5'h02; step();
    checks++; if (if_o !== 8'hE2) begin failures++; $display("FAIL req_beats_write got=%h exp=e2", if_o); end
    write_if(8'h00);
  endtask

  task automatic test_halt_bug();
    logic exp_bug;
`ifdef GB_CPU_HALT_BUG_EN
    exp_bug = 1'b1;
`else
    exp_bug = 1'b0;
`endif
    write_ie(8'h01);
    write_if(8'h01);
    halt_req = 1'b1; step();
    checks++; if (halt_bug !== exp_bug || halted !== 1'b0) begin failures++; $display("FAIL halt_bug_pulse got=%b/%b exp=%b/0", halt_bug, halted, exp_bug); end
    step();
    checks++; if (halt_bug !== 1'b0) begin failures++; $display("FAIL halt_bug_width got=%b exp=0", halt_bug); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_irq_basic();
    test_dispatch();
    test_ei_delay();
    test_halt();
    test_same_cycle();
    test_halt_bug();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
# gb_cpu_interrupt_ctrl

Interrupt controller for the Game Boy CPU core, upstream of the CPU scheduler.
- Holds the IE (0xFFFF) and IF (0xFF0F) registers, the IME master enable and the EI delay.
- Drives `interrupt_queued`, which the scheduler samples at instruction boundaries, and supplies the ISR vector.
- Consumes the scheduler's interrupt control signals and the HALT request, and owns the HALT low-power state.

## Interface
Parameters:
- `NUM_IRQ`, default 5: interrupt sources. Bit 0 is VBlank, then STAT, Timer, Serial, Joypad. Bit 0 has the highest priority.

Ports (clock and reset first):
- `clk`  in  1: machine (M) clock. This is the block's only clock.
- `reset`  in  1: synchronous, active-high reset.
- `irq_req`  in  NUM_IRQ: single-cycle request pulses from peripherals; each sets its IF bit.
- `ie_wr`, `if_wr`  in  1: CPU write strobes for IE and IF.
- `reg_wdata`  in  8: CPU write data.
- `ie_o`  out  8: IE read value.
- `if_o`  out  8: IF read value. Bits 7:5 read as 1.
- `enable_interrupts`  in  1: EI. IME is set after a delay.
- `reti_enable`  in  1: RETI. IME is set immediately.
- `disable_interrupts`  in  1: DI.
- `write_interrupt_vector`  in  1: latch the highest-priority pending source.
- `clear_interrupt_flag`  in  1: dispatch acknowledge.
- `instr_boundary`  in  1: high in the cycle where the scheduler's `curr_m_cycle == 0`.
- `halt_req`  in  1: HALT opcode executed.
- `interrupt_queued`  out  1: an interrupt will be dispatched instead of the next instruction.
- `isr_vector`  out  8: ISR target address, low byte.
- `ime_o`  out  1: current IME.
- `halted`  out  1: the CPU is in HALT and fetch is frozen.
- `halt_bug`  out  1: one-cycle pulse. Present only with the configuration macro.

## Operation
- `pending = ie[4:0] & if[4:0]`. `any_pending = |pending`.
- `interrupt_queued = ime & any_pending`. This output is combinational from registered state only.

IF register update:
- Next value is `(if_wr ? reg_wdata[4:0] : if)`, OR `irq_req`, AND NOT the acknowledge clear mask.
- A request arriving in the same cycle as a clear or a write of the same bit wins.

IE register:
- A write stores all 8 bits. Bits 7:5 are kept and read back as written.

IME and the EI delay:
- `enable_interrupts` sets `ime_pending`.
- On the first `instr_boundary` cycle after the EI cycle (with `ime_pending` already 1), `ime <= 1` and `ime_pending <= 0`.
- `reti_enable` sets `ime <= 1` at once and clears `ime_pending`.
- `disable_interrupts` clears both `ime` and `ime_pending`. It wins over `enable_interrupts` or `reti_enable` in the same cycle.
- EI while IME is already 1 has no visible effect.

Dispatch:
- On `write_interrupt_vector`, latch `vec_idx` = lowest set bit of `pending`, set `vec_valid = any_pending`, and drive `isr_vector = 0x40 + 8*vec_idx`.
- If nothing is pending (the request was cancelled by an IE/IF write between boundary and vector), `isr_vector = 0x00`.
- On `clear_interrupt_flag`, clear `if[vec_idx]` if `vec_valid`, clear `ime` and `ime_pending`, and clear `vec_valid`.
- `clear_interrupt_flag` and `write_interrupt_vector` in the same cycle: latch first, then clear the newly latched bit.

HALT state machine (RUN, HALT):
- From RUN on `halt_req`:
  - `any_pending == 0`: go to HALT.
  - `any_pending == 1` and `ime == 1`: stay in RUN; dispatch follows.
  - `any_pending == 1` and `ime == 0`: stay in RUN; `halt_bug` pulses (macro only).
- From HALT: return to RUN in the cycle after `any_pending` becomes 1, regardless of IME.
- `halted = (state == HALT)`.

## Timing
- All state updates on `posedge clk`.
- Reset values:
  - `ie = 0x00`, `if = 0x00` (so `if_o = 0xE0`).
  - `ime = 0`, `ime_pending = 0`, `vec_valid = 0`, `vec_idx = 0`.
  - `isr_vector = 0x00`, `halted = 0`, `halt_bug = 0`, state RUN, `interrupt_queued = 0`.
- Reset wins over every other input, including mid-dispatch and in HALT.
- Latency:
  - `irq_req` to IF set, and to `interrupt_queued` if IME=1 and IE enabled: 1 cycle.
  - EI to IME: IME rises at the edge ending the next `instr_boundary` cycle, so the instruction after EI always executes.
  - HALT exit: `halted` falls 1 cycle after the IF/IE update that makes `any_pending` 1.
- Register read values reflect the state after the last edge; there is no write-through.
- `halt_bug` is high for exactly one cycle after the `halt_req` edge.

## Configuration
- `GB_CPU_HALT_BUG_EN`:
  - Defined: `halt_bug` is implemented per Operation, and the fetch path suppresses one PC increment.
  - Undefined: `halt_bug` is tied to 0, and `halt_req` with IME=0 and a pending interrupt simply stays in RUN.

## Test plan
- Reset, then `ie_wr` 0x01, then `irq_req` 0x01 with IME=0 -> `if_o = 0xE1`, `interrupt_queued = 0`. After `reti_enable`, `interrupt_queued = 1` the next cycle.
- IE=0x1F, `irq_req` 0x14 (Timer + Joypad), IME=1, then `write_interrupt_vector` -> `isr_vector = 0x50`. After `clear_interrupt_flag`: `if_o = 0xF0`, `ime_o = 0`.
- EI, `instr_boundary` (EI fetch), then `instr_boundary` -> `ime_o` rises only after the second boundary. EI then DI before the boundary -> `ime_o` stays 0.
- IE=0x04, `halt_req` with IF=0 -> `halted = 1`. `irq_req` 0x04 -> `halted = 0` one cycle later. `interrupt_queued` follows IME.
- Same-cycle `irq_req` 0x01 and `clear_interrupt_flag` with `vec_idx = 0` -> `if[0]` remains 1. `if_wr` 0x00 with `irq_req` 0x02 -> `if_o = 0xE2`.
- With `GB_CPU_HALT_BUG_EN`: IME=0, IE=IF=0x01, `halt_req` -> `halt_bug` pulses for 1 cycle and `halted` stays 0. Without the macro, `halt_bug` stays 0.
